// File: rtl/torus_pkg.sv
// torus_pkg: shared controller states and index helpers for the torus array
package torus_pkg;
   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;
   localparam int NDIR = 4;
   function automatic int wrap_idx(input int i, input int n);
      return ((i % n) + n) % n;
   endfunction
   // dir names the input port of PE(r,c) that the link feeds
   function automatic bit is_wrap_link(input int r, input int c, input int dir, input int rows, input int cols);
      return dir == 0 ? c == 0 : dir == 1 ? r == 0 : dir == 2 ? c == cols - 1 : r == rows - 1;
   endfunction
   function automatic int ch_lsb(input int k, input int w);
      return k * w;
   endfunction
endpackage

// File: rtl/PE.sv
// PE: processing element that forwards In0 to every output, one register per busy cycle
module PE #(
   parameter int DWIDTH = 32
) (
   input  logic              Clk,
   input  logic              Resetn,
   input  logic              PE_Array_Busy,
   input  logic [DWIDTH-1:0] In0,
   input  logic [DWIDTH-1:0] In1,
   input  logic [DWIDTH-1:0] In2,
   input  logic [DWIDTH-1:0] In3,
   output logic [DWIDTH-1:0] Out0,
   output logic [DWIDTH-1:0] Out1,
   output logic [DWIDTH-1:0] Out2,
   output logic [DWIDTH-1:0] Out3
);
   logic [DWIDTH-1:0] r_q;
   logic              w_unused;
   assign w_unused = ^{In1, In2, In3};
   always_ff @(posedge Clk or negedge Resetn)
      if (!Resetn) r_q <= '0;
      else if (PE_Array_Busy) r_q <= In0;
   assign {Out0, Out1, Out2, Out3} = {4{r_q}};
endmodule

// File: rtl/PEIO.sv
// PEIO: load/store processing element; registers PE_Load onto its outputs and exposes In0 as PE_Store
module PEIO #(
   parameter int DWIDTH     = 32,
   parameter int SYS_DWIDTH = 32
) (
   input  logic                  Clk,
   input  logic                  Resetn,
   input  logic                  PE_Array_Busy,
   input  logic [DWIDTH-1:0]     In0,
   input  logic [DWIDTH-1:0]     In1,
   input  logic [DWIDTH-1:0]     In2,
   input  logic [DWIDTH-1:0]     In3,
   input  logic [SYS_DWIDTH-1:0] PE_Load,
   output logic [SYS_DWIDTH-1:0] PE_Store,
   output logic [DWIDTH-1:0]     Out0,
   output logic [DWIDTH-1:0]     Out1,
   output logic [DWIDTH-1:0]     Out2,
   output logic [DWIDTH-1:0]     Out3
);
   logic [DWIDTH-1:0] r_q;
   logic              w_unused;
   assign w_unused = ^{In1, In2, In3};
   always_ff @(posedge Clk or negedge Resetn)
      if (!Resetn) r_q <= '0;
      else if (PE_Array_Busy) r_q <= DWIDTH'(PE_Load);
   assign {Out0, Out1, Out2, Out3} = {4{r_q}};
   assign PE_Store = SYS_DWIDTH'(In0);
endmodule

// File: rtl/torus_link_pipe.sv
// torus_link_pipe: enable-gated register chain on a wrap-around link; plain wire when STAGES is 0
module torus_link_pipe #(
   parameter int DWIDTH = 32,
   parameter int STAGES = 1
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_en,
   input  logic [DWIDTH-1:0] i_d,
   output logic [DWIDTH-1:0] o_q
);
   if (STAGES == 0) begin : g_wire
      logic w_unused;
      assign w_unused = i_clk ^ i_rst ^ i_en;
      assign o_q = i_d;
   end else begin : g_pipe
      logic [DWIDTH-1:0] r_q [STAGES];
      always_ff @(posedge i_clk or posedge i_rst)
         if (i_rst) begin
            for (int i = 0; i < STAGES; i++) r_q[i] <= '0;
         end else if (i_en) begin
            r_q[0] <= i_d;
            for (int i = 1; i < STAGES; i++) r_q[i] <= r_q[i-1];
         end
      assign o_q = r_q[STAGES-1];
   end
endmodule

// File: rtl/torus_array.sv
// torus_array: ROWSxCOLS torus of PEs with pipelined wrap-around links and a run/drain controller
module torus_array
   import torus_pkg::*;
#(
   parameter int ROWS        = 6,
   parameter int COLS        = 6,
   parameter int DWIDTH      = 32,
   parameter int SYS_DWIDTH  = 32,
   parameter int IO_CH       = 2,
   parameter int WRAP_STAGES = 1,
   parameter int CNT_W       = 16
) (
   input  logic                        Clk,
   input  logic                        Reset,
   input  logic                        Start,
   input  logic [CNT_W-1:0]            Run_Cycles,
   input  logic [IO_CH*SYS_DWIDTH-1:0] Data_Load,
   output logic [IO_CH*SYS_DWIDTH-1:0] Data_Store,
   output logic                        Busy,
   output logic                        Done
);
   localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
   localparam logic [CNT_W-1:0] DRAIN_LEN = CNT_W'(WRAP_STAGES);

   state_t                      r_state;
   logic [CNT_W-1:0]            r_cnt;
   logic                        r_busy;
   logic                        r_done;
   logic [IO_CH*SYS_DWIDTH-1:0] r_store;
   logic [IO_CH*SYS_DWIDTH-1:0] w_store;
   logic                        w_resetn;
   logic [DWIDTH-1:0]           w_out [ROWS][COLS][NDIR];
   logic [DWIDTH-1:0]           w_in  [ROWS][COLS][NDIR];

   assign w_resetn   = ~Reset;
   assign Busy       = r_busy;
   assign Done       = r_done;
   assign Data_Store = r_store;

   always_ff @(posedge Clk or posedge Reset)
      if (Reset) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: if (Start) begin
               r_cnt   <= Run_Cycles;
               r_busy  <= Run_Cycles != '0;
               r_done  <= Run_Cycles == '0;
               r_state <= Run_Cycles != '0 ? S_RUN : S_DONE;
            end
            S_RUN: begin
               r_cnt <= r_cnt - ONE;
               if (r_cnt == ONE) begin
                  r_cnt   <= DRAIN_LEN;
                  r_busy  <= WRAP_STAGES != 0;
                  r_done  <= WRAP_STAGES == 0;
                  r_state <= WRAP_STAGES != 0 ? S_DRAIN : S_DONE;
               end
            end
            S_DRAIN: begin
               r_cnt <= r_cnt - ONE;
               if (r_cnt == ONE) begin
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_state <= S_DONE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end

   always_ff @(posedge Clk or posedge Reset)
      if (Reset) r_store <= '0;
      else if (r_busy) r_store <= w_store;

   for (genvar r = 0; r < ROWS; r++) begin : g_r
      for (genvar c = 0; c < COLS; c++) begin : g_c
         // input d of PE(r,c) is fed by output (d+2)%4 of the neighbour on that side
         for (genvar d = 0; d < NDIR; d++) begin : g_d
            localparam int SR = d == 1 ? wrap_idx(r - 1, ROWS) : d == 3 ? wrap_idx(r + 1, ROWS) : r;
            localparam int SC = d == 0 ? wrap_idx(c - 1, COLS) : d == 2 ? wrap_idx(c + 1, COLS) : c;
            if (is_wrap_link(r, c, d, ROWS, COLS)) begin : g_wrap
               torus_link_pipe #(.DWIDTH(DWIDTH), .STAGES(WRAP_STAGES)) u_pipe (
                  .i_clk (Clk),
                  .i_rst (Reset),
                  .i_en  (r_busy),
                  .i_d   (w_out[SR][SC][(d+2)%NDIR]),
                  .o_q   (w_in[r][c][d])
               );
            end else begin : g_mesh
               assign w_in[r][c][d] = w_out[SR][SC][(d+2)%NDIR];
            end
         end
         if (r == 0 && c < IO_CH) begin : g_io
            PEIO #(.DWIDTH(DWIDTH), .SYS_DWIDTH(SYS_DWIDTH)) u_pe (
               .Clk           (Clk),
               .Resetn        (w_resetn),
               .PE_Array_Busy (r_busy),
               .In0           (w_in[r][c][0]),
               .In1           (w_in[r][c][1]),
               .In2           (w_in[r][c][2]),
               .In3           (w_in[r][c][3]),
               .PE_Load       (Data_Load[ch_lsb(c, SYS_DWIDTH) +: SYS_DWIDTH]),
               .PE_Store      (w_store[ch_lsb(c, SYS_DWIDTH) +: SYS_DWIDTH]),
               .Out0          (w_out[r][c][0]),
               .Out1          (w_out[r][c][1]),
               .Out2          (w_out[r][c][2]),
               .Out3          (w_out[r][c][3])
            );
         end else begin : g_pe
            PE #(.DWIDTH(DWIDTH)) u_pe (
               .Clk           (Clk),
               .Resetn        (w_resetn),
               .PE_Array_Busy (r_busy),
               .In0           (w_in[r][c][0]),
               .In1           (w_in[r][c][1]),
               .In2           (w_in[r][c][2]),
               .In3           (w_in[r][c][3]),
               .Out0          (w_out[r][c][0]),
               .Out1          (w_out[r][c][1]),
               .Out2          (w_out[r][c][2]),
               .Out3          (w_out[r][c][3])
            );
         end
      end
   end
endmodule
